// File: rtl/data_mem_responder_pkg.sv
// Shared data-memory definitions: word width, access size codes, responder FSM states
// and the captured-request record. Reused by the CPU datapath.
package data_mem_responder_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HWORD = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  typedef logic [1:0] dmem_state_t;
  localparam dmem_state_t StIdle = 2'd0;
  localparam dmem_state_t StWait = 2'd1;
  localparam dmem_state_t StResp = 2'd2;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic                  we;
    logic [WORD_WIDTH-1:0] wdata;
  } dmem_req_t;

  // Lane used once the low address bits that a size cannot address are dropped.
  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_HWORD: force_align = {lo[1], 1'b0};
      SIZE_WORD:  force_align = 2'b00;
      default:    force_align = lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: byte enables, store-data shift and
// right-justified, zero-extended load extraction.
module dmem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]            size_i,
  input  logic [1:0]            lane_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  input  logic [WORD_WIDTH-1:0] rword_i,
  output logic [3:0]            be_o,
  output logic [WORD_WIDTH-1:0] wdata_o,
  output logic [WORD_WIDTH-1:0] rdata_o
);

  logic [4:0]            shamt;
  logic [WORD_WIDTH-1:0] rshift;

  assign shamt   = {lane_i, 3'b000};
  assign wdata_o = wdata_i << shamt;
  assign rshift  = rword_i >> shamt;

  always_comb begin
    be_o    = 4'b0000;
    rdata_o = '0;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << lane_i;
        rdata_o = {24'h0, rshift[7:0]};
      end
      SIZE_HWORD: begin
        be_o    = 4'b0011 << lane_i;
        rdata_o = {16'h0, rshift[15:0]};
      end
      SIZE_WORD: begin
        be_o    = 4'b1111;
        rdata_o = rshift;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder with valid/ready request and response channels.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses instead of force-aligning them.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [WORD_WIDTH-1:0] req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_we_i,
  input  logic [WORD_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WORD_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o
);

  localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CntInit    = 4'(LATENCY - 1);
  localparam bit          DirectResp = (LATENCY == 1);

  dmem_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  dmem_req_t             req_q, req_d, req_in, cur;
  logic [WORD_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic                  accept, to_resp, oob, size_bad, err;
  logic [29:0]           widx;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [WORD_WIDTH-1:0] rword, wdata_sh, load_data;

  always_comb begin
    req_in.addr  = req_addr_i;
    req_in.size  = req_size_i;
    req_in.we    = req_we_i;
    req_in.wdata = req_wdata_i;
  end

  assign accept  = req_valid_i && (state_q == StIdle);
  assign to_resp = ((state_q == StWait) && (cnt_q == 4'd0)) || (accept && DirectResp);
  // With LATENCY=1 the response is formed on the acceptance edge, before capture.
  assign cur     = (state_q == StIdle) ? req_in : req_q;

  assign widx     = cur.addr[31:2];
  assign oob      = ({2'b00, widx} >= 32'(DEPTH_WORDS));
  assign size_bad = (cur.size == 2'b11);
  assign lane     = force_align(cur.size, cur.addr[1:0]);

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = ((cur.size == SIZE_HWORD) && cur.addr[0]) ||
                    ((cur.size == SIZE_WORD) && (cur.addr[1:0] != 2'b00));
  assign err      = oob || size_bad || misalign;
`else
  assign err      = oob || size_bad;
`endif

  assign rword = mem_q[widx[AW-1:0]];

  dmem_lane_align u_lane_align (
    .size_i  (cur.size),
    .lane_i  (lane),
    .wdata_i (cur.wdata),
    .rword_i (rword),
    .be_o    (be),
    .wdata_o (wdata_sh),
    .rdata_o (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          req_d   = req_in;
          cnt_d   = CntInit;
          state_d = DirectResp ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d    = StIdle;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (to_resp) begin
      rsp_err_d  = err;
      rsp_data_d = (err || cur.we) ? '0 : load_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      req_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Storage is not reset; a store lands only on the edge that enters RESP.
  always_ff @(posedge clk_i) begin
    if (rst_ni && to_resp && cur.we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[widx[AW-1:0]][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, reset corner
// sequences and randomized traffic checked against a byte-array memory model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [DEPTH*4];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_size_i  (req_size),
    .req_we_i    (req_we),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
  endtask

  // Memory as a plain byte array; misaligned accesses round down to their natural boundary.
  task automatic ref_access(input logic [31:0] a, input logic [1:0] s, input logic w,
                            input logic [31:0] d, output logic [31:0] ed, output logic ee);
    int          n;
    logic [31:0] ea;
    logic        mis;
    ed  = '0;
    ee  = 1'b0;
    mis = (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    if (s == 2'd3 || a >= 32'(DEPTH * 4) || (AlignChk && mis)) begin
      ee = 1'b1;
      return;
    end
    n  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    ea = a - (a % n);
    for (int i = 0; i < n; i++) begin
      if (w) ref_mem[ea + i] = d[8*i +: 8];
      else   ed = ed | (32'(ref_mem[ea + i]) << (8 * i));
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [1:0] s, input logic w,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] rd, output logic re);
    int n;
    rd = '0;
    re = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_we    = w;
    req_wdata = d;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request bus: the captured copy must be used.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_size  = 2'($urandom);
    req_we    = 1'($urandom);
    req_wdata = $urandom;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(LAT));
    if (!rsp_valid) return;
    rd = rsp_data;
    re = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, rd);
      chk("hold_err", {31'b0, rsp_err}, {31'b0, re});
      chk("hold_busy", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("release_ready", {31'b0, req_ready}, 32'd1);
    chk("release_valid", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [1:0] s, input logic w,
                         input logic [31:0] d, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.addr = a; v.size = s; v.we = w; v.wdata = d; v.exp_data = ed; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, ed, wd, a;
    logic        re, ee, w;
    logic [1:0]  s;

    // Directed table
    add_vec(32'h10, 2'd2, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    add_vec(32'h10, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    add_vec(32'h12, 2'd0, 1'b1, 32'h00000055, 32'h0, 1'b0);
    add_vec(32'h10, 2'd2, 1'b0, 32'h0, 32'hDE55BEEF, 1'b0);
    add_vec(32'h13, 2'd0, 1'b0, 32'h0, 32'h000000DE, 1'b0);
    add_vec(32'h12, 2'd1, 1'b0, 32'h0, 32'h0000DE55, 1'b0);
    add_vec(32'h11, 2'd2, 1'b0, 32'h0, AlignChk ? 32'h0 : 32'hDE55BEEF, AlignChk);
    add_vec(32'h00, 2'd2, 1'b1, 32'h11111111, 32'h0, 1'b0);
    add_vec(32'h100, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    add_vec(32'h100, 2'd2, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1);
    add_vec(32'h00, 2'd3, 1'b1, 32'h22222222, 32'h0, 1'b1);
    add_vec(32'h00, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
    add_vec(32'h00, 2'd2, 1'b0, 32'h0, 32'h11111111, 1'b0);
    add_vec(32'h10, 2'd2, 1'b0, 32'h0, 32'hDE55BEEF, 1'b0);
    add_vec(32'h13, 2'd1, 1'b1, 32'h0000ABCD, 32'h0, AlignChk);
    add_vec(32'h11, 2'd0, 1'b1, 32'hFFFFFF77, 32'h0, 1'b0);
    add_vec(32'h10, 2'd2, 1'b0, 32'h0, AlignChk ? 32'hDE5577EF : 32'hABCD77EF, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every word so later loads have defined contents
    for (int i = 0; i < int'(DEPTH); i++) begin
      wd = $urandom;
      ref_access(32'(i * 4), 2'd2, 1'b1, wd, ed, ee);
      txn(32'(i * 4), 2'd2, 1'b1, wd, 0, rd, re);
      chk("init_err", {31'b0, re}, 32'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      ref_access(vecs[i].addr, vecs[i].size, vecs[i].we, vecs[i].wdata, ed, ee);
      txn(vecs[i].addr, vecs[i].size, vecs[i].we, vecs[i].wdata, 0, rd, re);
      chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {31'b0, re}, {31'b0, vecs[i].exp_err});
    end

    // Response held for 5 cycles
    ref_access(32'h10, 2'd2, 1'b0, 32'h0, ed, ee);
    txn(32'h10, 2'd2, 1'b0, 32'h0, 5, rd, re);
    chk("hold_load_data", rd, ed);

    // Reset during WAIT aborts the pending store
    ref_access(32'h20, 2'd2, 1'b1, 32'h12345678, ed, ee);
    txn(32'h20, 2'd2, 1'b1, 32'h12345678, 0, rd, re);
    chk("pre_abort_err", {31'b0, re}, 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h20; req_size = 2'd2; req_we = 1'b1;
    req_wdata = 32'hAAAAAAAA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_in_wait", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_wait_a");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_reset_outputs("rst_wait_b");
    end
    @(negedge clk);
    rst_n = 1'b1;
    txn(32'h20, 2'd2, 1'b0, 32'h0, 0, rd, re);
    chk("abort_load", rd, 32'h12345678);

    // Reset during RESP keeps the committed store
    ref_access(32'h24, 2'd2, 1'b1, 32'h0BADF00D, ed, ee);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h24; req_size = 2'd2; req_we = 1'b1;
    req_wdata = 32'h0BADF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("resp_before_rst", {31'b0, rsp_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_resp");
    @(negedge clk);
    rst_n = 1'b1;
    ref_access(32'h24, 2'd2, 1'b0, 32'h0, ed, ee);
    txn(32'h24, 2'd2, 1'b0, 32'h0, 0, rd, re);
    chk("resp_rst_load", rd, ed);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, DEPTH * 4 + 31));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      s  = 2'($urandom);
      w  = 1'($urandom);
      wd = $urandom;
      ref_access(a, s, w, wd, ed, ee);
      txn(a, s, w, wd, int'($urandom_range(0, 2)), rd, re);
      chk($sformatf("rnd%0d_data a=%h s=%0d w=%0d", i, a, s, w), rd, ed);
      chk($sformatf("rnd%0d_err a=%h s=%0d w=%0d", i, a, s, w), {31'b0, re}, {31'b0, ee});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
